// File: rtl/micro_sequencer_stack.sv
// Next-address microsequencer: holds the micro-PC and picks the next micro-address
// by increment, jump, dispatch, branch, wait, or call/return on a small return stack.
module micro_sequencer_stack #(
  parameter int AW         = 8,
  parameter int NCOND      = 4,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0,
  localparam int CSW       = (NCOND > 1) ? $clog2(NCOND) : 1,
  localparam int SPW       = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_ns_mode,
  input  logic             i_inv,
  input  logic [CSW-1:0]   i_cond_sel,
  input  logic [AW-1:0]    i_target,
  input  logic [AW-1:0]    i_disp_addr,
  input  logic [NCOND-1:0] i_cond_in,
  input  logic             i_hold,
  input  logic             i_err_clr,
  output logic [AW-1:0]    o_uaddr,
  output logic [SPW-1:0]   o_sp_level,
  output logic             o_stack_full,
  output logic             o_stack_empty,
  output logic             o_ovf,
  output logic             o_unf
);

  typedef enum logic [2:0] {
    NS_INC  = 3'd0,
    NS_JMP  = 3'd1,
    NS_DISP = 3'd2,
    NS_CBR  = 3'd3,
    NS_WAIT = 3'd4,
    NS_CALL = 3'd5,
    NS_RET  = 3'd6,
    NS_RST  = 3'd7
  } ns_mode_e;

  // Memory is sized to the full pointer range so the stack pointer indexes it directly.
  localparam int              MEMN    = 1 << SPW;
  localparam logic [AW-1:0]   RST_A   = AW'(RESET_ADDR);
  localparam logic [AW-1:0]   A_ONE   = AW'(1);
  localparam logic [SPW-1:0]  SP_ZERO = SPW'(0);
  localparam logic [SPW-1:0]  SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0]  DEPTH_L = SPW'(DEPTH);

  logic [AW-1:0]  r_upc;
  logic [SPW-1:0] r_sp;
  logic           r_full;
  logic           r_empty;
  logic           r_ovf;
  logic           r_unf;
  logic [AW-1:0]  r_mem [MEMN];

  logic [AW-1:0]  w_inc;
  logic [SPW-1:0] w_sp_dec;
  logic           w_cond;
  logic           w_t;
  logic [AW-1:0]  w_next;
  logic [SPW-1:0] w_sp_next;
  logic           w_push;
  logic           w_ovf_set;
  logic           w_unf_set;
  logic           w_ovf_next;
  logic           w_unf_next;
  ns_mode_e       w_mode;

  assign w_mode   = ns_mode_e'(i_ns_mode);
  assign w_inc    = r_upc + A_ONE;
  assign w_sp_dec = r_sp - SP_ONE;

  // Selected condition; out-of-range selects read as 0 before inversion.
  always_comb begin
    w_cond = 1'b0;
    if ({{(32-CSW){1'b0}}, i_cond_sel} < NCOND) begin
      w_cond = i_cond_in[i_cond_sel];
    end else begin
      w_cond = 1'b0;
    end
    w_t = w_cond ^ i_inv;
  end

  // Next-address, stack-pointer and error-event decode.
  always_comb begin
    w_next    = w_inc;
    w_sp_next = r_sp;
    w_push    = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (w_mode)
      NS_INC:  w_next = w_inc;
      NS_JMP:  w_next = i_target;
      NS_DISP: w_next = i_disp_addr;
      NS_CBR:  w_next = w_t ? i_target : w_inc;
      NS_WAIT: w_next = w_t ? w_inc : r_upc;
      NS_CALL: begin
        w_next = i_target;
        if (r_full) begin
          w_ovf_set = 1'b1;
        end else begin
          w_push    = 1'b1;
          w_sp_next = r_sp + SP_ONE;
        end
      end
      NS_RET: begin
        if (r_empty) begin
          w_next    = RST_A;
          w_unf_set = 1'b1;
        end else begin
          w_next    = r_mem[w_sp_dec];
          w_sp_next = w_sp_dec;
        end
      end
      NS_RST: begin
        w_next    = RST_A;
        w_sp_next = SP_ZERO;
      end
      default: w_next = w_inc;
    endcase
    // A new error outranks a simultaneous clear; hold suppresses new errors only.
    w_ovf_next = (r_ovf & ~i_err_clr) | (w_ovf_set & ~i_hold);
    w_unf_next = (r_unf & ~i_err_clr) | (w_unf_set & ~i_hold);
  end

  // Micro-PC, stack pointer, status and sticky flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_upc   <= RST_A;
      r_sp    <= SP_ZERO;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (!i_hold) begin
        r_upc   <= w_next;
        r_sp    <= w_sp_next;
        r_full  <= (w_sp_next == DEPTH_L);
        r_empty <= (w_sp_next == SP_ZERO);
      end else begin
        r_upc   <= r_upc;
        r_sp    <= r_sp;
        r_full  <= r_full;
        r_empty <= r_empty;
      end
      r_ovf <= w_ovf_next;
      r_unf <= w_unf_next;
    end
  end

  // Return-stack storage; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_hold && i_rst_n) begin
      r_mem[r_sp] <= w_inc;
    end
  end

  assign o_uaddr       = r_upc;
  assign o_sp_level    = r_sp;
  assign o_stack_full  = r_full;
  assign o_stack_empty = r_empty;
  assign o_ovf         = r_ovf;
  assign o_unf         = r_unf;

endmodule

// File: tb/tb_micro_sequencer_stack.sv
// Directed self-checking bench for micro_sequencer_stack (AW=8, NCOND=4, DEPTH=4).
module tb_micro_sequencer_stack;

  logic       clk;
  logic       rst_n;
  logic [2:0] ns_mode;
  logic       inv;
  logic [1:0] cond_sel;
  logic [7:0] target;
  logic [7:0] disp_addr;
  logic [3:0] cond_in;
  logic       hold;
  logic       err_clr;
  logic [7:0] uaddr;
  logic [2:0] sp_level;
  logic       stack_full;
  logic       stack_empty;
  logic       ovf;
  logic       unf;

  int checks;
  int failures;

  micro_sequencer_stack #(.AW(8), .NCOND(4), .DEPTH(4), .RESET_ADDR(0)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ns_mode     (ns_mode),
    .i_inv         (inv),
    .i_cond_sel    (cond_sel),
    .i_target      (target),
    .i_disp_addr   (disp_addr),
    .i_cond_in     (cond_in),
    .i_hold        (hold),
    .i_err_clr     (err_clr),
    .o_uaddr       (uaddr),
    .o_sp_level    (sp_level),
    .o_stack_full  (stack_full),
    .o_stack_empty (stack_empty),
    .o_ovf         (ovf),
    .o_unf         (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [7:0] a);
    ns_mode = 3'd1; target = a; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ns_mode = 3'd0; inv = 1'b0; cond_sel = 2'd0; target = 8'd0;
    disp_addr = 8'd0; cond_in = 4'd0; hold = 1'b0; err_clr = 1'b0;
    tick(); tick();
    checks++; if (uaddr !== 8'd0) begin failures++; $display("FAIL reset_uaddr got=%0d exp=0", uaddr); end
    checks++; if (sp_level !== 3'd0) begin failures++; $display("FAIL reset_sp got=%0d exp=0", sp_level); end
    checks++; if ({stack_full, stack_empty, ovf, unf} !== 4'b0100) begin
      failures++; $display("FAIL reset_flags got full/empty/ovf/unf=%b exp=0100", {stack_full, stack_empty, ovf, unf});
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_inc_wrap();
    jump_to(8'hFE);
    checks++; if (uaddr !== 8'hFE) begin failures++; $display("FAIL wrap_setup got=%h exp=fe", uaddr); end
    ns_mode = 3'd0;
    tick();
    checks++; if (uaddr !== 8'hFF) begin failures++; $display("FAIL wrap_ff got=%h exp=ff", uaddr); end
    tick();
    checks++; if (uaddr !== 8'h00) begin failures++; $display("FAIL wrap_00 got=%h exp=00", uaddr); end
  endtask

  task automatic test_wait_cbr();
    jump_to(8'd5);
    ns_mode = 3'd4; cond_sel = 2'd0; inv = 1'b0; cond_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (uaddr !== 8'd5) begin failures++; $display("FAIL wait_stall%0d got=%0d exp=5", i, uaddr); end
    end
    cond_in = 4'b0001;
    tick();
    checks++; if (uaddr !== 8'd6) begin failures++; $display("FAIL wait_release got=%0d exp=6", uaddr); end
    ns_mode = 3'd3; inv = 1'b1; cond_sel = 2'd1; cond_in = 4'b0010; target = 8'd40;
    tick();
    checks++; if (uaddr !== 8'd7) begin failures++; $display("FAIL cbr_not_taken got=%0d exp=7", uaddr); end
    inv = 1'b0;
    tick();
    checks++; if (uaddr !== 8'd40) begin failures++; $display("FAIL cbr_taken got=%0d exp=40", uaddr); end
    ns_mode = 3'd4; cond_sel = 2'd3; cond_in = 4'b0111; inv = 1'b1;
    tick();
    checks++; if (uaddr !== 8'd41) begin failures++; $display("FAIL wait_sel3_inv got=%0d exp=41", uaddr); end
    inv = 1'b0; cond_in = 4'b0000;
  endtask

  task automatic test_disp_jmp();
    ns_mode = 3'd2; disp_addr = 8'd38;
    tick();
    checks++; if (uaddr !== 8'd38) begin failures++; $display("FAIL disp got=%0d exp=38", uaddr); end
    jump_to(8'd3);
    checks++; if (uaddr !== 8'd3) begin failures++; $display("FAIL jmp got=%0d exp=3", uaddr); end
  endtask

  task automatic test_nesting();
    logic [2:0] modes [4];
    logic [7:0] tgts  [4];
    logic [7:0] exp_a [4];
    logic [2:0] exp_s [4];
    modes = '{3'd5, 3'd5, 3'd6, 3'd6};
    tgts  = '{8'd20, 8'd30, 8'd0, 8'd0};
    exp_a = '{8'd20, 8'd30, 8'd21, 8'd11};
    exp_s = '{3'd1, 3'd2, 3'd1, 3'd0};
    jump_to(8'd10);
    for (int i = 0; i < 4; i++) begin
      ns_mode = modes[i]; target = tgts[i];
      tick();
      checks++; if (uaddr !== exp_a[i] || sp_level !== exp_s[i]) begin
        failures++; $display("FAIL nest_step%0d got uaddr=%0d sp=%0d exp uaddr=%0d sp=%0d", i, uaddr, sp_level, exp_a[i], exp_s[i]);
      end
    end
    checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL nest_empty got=%b exp=1", stack_empty); end
  endtask

  task automatic test_errors();
    logic [7:0] ret_a [3];
    ret_a = '{8'd121, 8'd111, 8'd101};
    jump_to(8'd100);
    for (int i = 1; i <= 4; i++) begin
      ns_mode = 3'd5; target = 8'(100 + 10 * i);
      tick();
    end
    checks++; if (uaddr !== 8'd140 || sp_level !== 3'd4 || stack_full !== 1'b1 || ovf !== 1'b0) begin
      failures++; $display("FAIL call4 got uaddr=%0d sp=%0d full=%b ovf=%b exp 140/4/1/0", uaddr, sp_level, stack_full, ovf);
    end
    target = 8'd150;
    tick();
    checks++; if (uaddr !== 8'd150 || sp_level !== 3'd4 || stack_full !== 1'b1 || ovf !== 1'b1) begin
      failures++; $display("FAIL call5_ovf got uaddr=%0d sp=%0d full=%b ovf=%b exp 150/4/1/1", uaddr, sp_level, stack_full, ovf);
    end
    ns_mode = 3'd6;
    tick();
    checks++; if (uaddr !== 8'd131 || sp_level !== 3'd3 || stack_full !== 1'b0) begin
      failures++; $display("FAIL ret1 got uaddr=%0d sp=%0d full=%b exp 131/3/0", uaddr, sp_level, stack_full);
    end
    hold = 1'b1; ns_mode = 3'd5; target = 8'd200;
    tick();
    checks++; if (uaddr !== 8'd131 || sp_level !== 3'd3) begin
      failures++; $display("FAIL hold_call got uaddr=%0d sp=%0d exp 131/3", uaddr, sp_level);
    end
    hold = 1'b0; ns_mode = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (uaddr !== ret_a[i] || sp_level !== 3'(2 - i)) begin
        failures++; $display("FAIL unwind%0d got uaddr=%0d sp=%0d exp uaddr=%0d sp=%0d", i, uaddr, sp_level, ret_a[i], 2 - i);
      end
    end
    checks++; if (unf !== 1'b0 || stack_empty !== 1'b1) begin
      failures++; $display("FAIL pre_unf got unf=%b empty=%b exp 0/1", unf, stack_empty);
    end
    tick();
    checks++; if (uaddr !== 8'd0 || unf !== 1'b1 || sp_level !== 3'd0 || ovf !== 1'b1) begin
      failures++; $display("FAIL ret_unf got uaddr=%0d unf=%b sp=%0d ovf=%b exp 0/1/0/1", uaddr, unf, sp_level, ovf);
    end
    hold = 1'b1; err_clr = 1'b1; ns_mode = 3'd1; target = 8'd99;
    tick();
    checks++; if (ovf !== 1'b0 || unf !== 1'b0 || uaddr !== 8'd0) begin
      failures++; $display("FAIL clr_in_hold got ovf=%b unf=%b uaddr=%0d exp 0/0/0", ovf, unf, uaddr);
    end
    hold = 1'b0; ns_mode = 3'd6;
    tick();
    checks++; if (unf !== 1'b1 || uaddr !== 8'd0) begin
      failures++; $display("FAIL set_beats_clr got unf=%b uaddr=%0d exp 1/0", unf, uaddr);
    end
    ns_mode = 3'd0;
    tick();
    checks++; if (unf !== 1'b0 || uaddr !== 8'd1) begin
      failures++; $display("FAIL clr_again got unf=%b uaddr=%0d exp 0/1", unf, uaddr);
    end
    err_clr = 1'b0;
  endtask

  task automatic test_rst_mode();
    jump_to(8'd77);
    ns_mode = 3'd5; target = 8'd80;
    tick();
    checks++; if (uaddr !== 8'd80 || sp_level !== 3'd1) begin
      failures++; $display("FAIL rstmode_call got uaddr=%0d sp=%0d exp 80/1", uaddr, sp_level);
    end
    ns_mode = 3'd7;
    tick();
    checks++; if (uaddr !== 8'd0 || sp_level !== 3'd0 || stack_empty !== 1'b1) begin
      failures++; $display("FAIL rstmode got uaddr=%0d sp=%0d empty=%b exp 0/0/1", uaddr, sp_level, stack_empty);
    end
  endtask

  task automatic test_async_reset();
    ns_mode = 3'd6;
    tick();
    ns_mode = 3'd5; target = 8'd60;
    tick();
    checks++; if (uaddr !== 8'd60 || sp_level !== 3'd1 || unf !== 1'b1) begin
      failures++; $display("FAIL areset_setup got uaddr=%0d sp=%0d unf=%b exp 60/1/1", uaddr, sp_level, unf);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (uaddr !== 8'd0 || sp_level !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0 || stack_empty !== 1'b1) begin
      failures++; $display("FAIL areset got uaddr=%0d sp=%0d ovf=%b unf=%b empty=%b exp 0/0/0/0/1", uaddr, sp_level, ovf, unf, stack_empty);
    end
    ns_mode = 3'd0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (uaddr !== 8'd1) begin failures++; $display("FAIL post_reset_inc got=%0d exp=1", uaddr); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_inc_wrap();
    test_wait_cbr();
    test_disp_jmp();
    test_nesting();
    test_errors();
    test_rst_mode();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
